// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES key expansion: one schedule word per cycle into a flat word store,
// with a registered round-key read port. One shared SubWord (four byte lanes).

module aes_sbox_lane (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };
  assign y = SBOX[a];
endmodule

module aes_key_sched_ctrl #(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [32*Nk-1:0]  key,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic              rk_lock,
  output logic              sched_valid,
  output logic              busy,
  input  logic [3:0]        rk_idx,
  output logic [127:0]      rk
);
  localparam int NW = 4*(Nr+1);
  localparam int IW = $clog2(NW+1);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
  state_t state, state_nx;

  logic [31:0]   w [NW];
  logic [IW-1:0] i, ip, im, rb;
  logic [2:0]    j;      // i mod Nk, kept as a wrapping counter to avoid a divider
  logic [7:0]    rcon;
  logic [31:0]   w_prev, w_old, sub_in, sub_out, w_new;
  logic          accept, last, rd_ok;

  assign key_ready = (state != EXPAND) && !rk_lock;
  assign busy      = (state == EXPAND);
  assign accept    = key_valid && key_ready;
  assign last      = (i == IW'(NW-1));

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (accept) state_nx = EXPAND;
      EXPAND:     if (last)   state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  assign ip     = i - 1'b1;
  assign im     = i - IW'(Nk);
  assign w_prev = w[ip];
  assign w_old  = w[im];
  assign sub_in = (j == 3'd0) ? {w_prev[7:0], w_prev[31:8]} : w_prev;

  for (genvar b = 0; b < 4; b++) begin : g_sb
    aes_sbox_lane u_sb (.a(sub_in[8*b +: 8]), .y(sub_out[8*b +: 8]));
  end

  always_comb begin
    w_new = w_old ^ w_prev;
    if (j == 3'd0)                    w_new = w_old ^ sub_out ^ {24'h0, rcon};
    else if ((Nk > 6) && (j == 3'd4)) w_new = w_old ^ sub_out;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i           <= '0;
      j           <= '0;
      rcon        <= 8'h01;
      sched_valid <= 1'b0;
      for (int k = 0; k < NW; k++) w[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < Nk; k++) w[k] <= key[32*k +: 32];
      i           <= IW'(Nk);
      j           <= '0;
      rcon        <= 8'h01;
      sched_valid <= 1'b0;
    end else if (state == EXPAND) begin
      w[i] <= w_new;
      i    <= i + 1'b1;
      j    <= (j == 3'(Nk-1)) ? 3'd0 : j + 3'd1;
      if (j == 3'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      if (last) sched_valid <= 1'b1;
    end
  end

  // Out-of-range indices read as zero rather than aliasing into the store.
  assign rd_ok = (rk_idx <= 4'(Nr));
  assign rb    = rd_ok ? IW'({rk_idx, 2'b00}) : '0;

  always_ff @(posedge clk or posedge reset)
    if (reset)      rk <= '0;
    else if (rd_ok) rk <= {w[rb + IW'(3)], w[rb + IW'(2)], w[rb + IW'(1)], w[rb]};
    else            rk <= '0;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Scoreboarded bench for the key scheduler: Nk=4 and Nk=8 instances against a
// byte-level FIPS-197 expansion with an S-box derived from GF(2^8) arithmetic.

module tb_aes_key_sched_ctrl;
  logic clk = 1'b0, reset;
  logic [255:0] key;
  logic [1:0] kv, rl, kr, sv, bz, rd_en;
  logic [1:0][3:0] idx;
  logic [1:0][127:0] rko;

  int n_chk = 0, n_fail = 0;
  logic [127:0] q0[$], q1[$];
  logic [7:0]  sb [256];
  logic [7:0]  kb [32];
  logic [31:0] ew [60];

  always #5 clk = ~clk;

  aes_key_sched_ctrl #(.Nk(4)) dut4 (
    .clk(clk), .reset(reset), .key(key[127:0]), .key_valid(kv[0]), .key_ready(kr[0]),
    .rk_lock(rl[0]), .sched_valid(sv[0]), .busy(bz[0]), .rk_idx(idx[0]), .rk(rko[0]));

  aes_key_sched_ctrl #(.Nk(8)) dut8 (
    .clk(clk), .reset(reset), .key(key), .key_valid(kv[1]), .key_ready(kr[1]),
    .rk_lock(rl[1]), .sched_valid(sv[1]), .busy(bz[1]), .rk_idx(idx[1]), .rk(rko[1]));

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic hi;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b  = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] x, int n);
    logic [15:0] d = {x, x};
    d = d >> (8 - n);
    return d[7:0];
  endfunction

  function automatic logic [7:0] sbox_calc(logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int c = 1; c < 256; c++) if (gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] bs(logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // FIPS-197 key expansion on byte arrays; ew[] holds words in the port's byte order.
  task automatic model(int nk);
    logic [7:0] wb [60][4];
    logic [7:0] t [4];
    logic [7:0] rc, t0;
    int nw = 4 * (nk + 7);
    for (int i = 0; i < nk; i++)
      for (int b = 0; b < 4; b++) wb[i][b] = kb[4*i + b];
    for (int i = nk; i < nw; i++) begin
      for (int b = 0; b < 4; b++) t[b] = wb[i-1][b];
      if (i % nk == 0) begin
        t0 = t[0]; t[0] = t[1]; t[1] = t[2]; t[2] = t[3]; t[3] = t0;
        for (int b = 0; b < 4; b++) t[b] = sb[t[b]];
        rc = 8'h01;
        for (int k = 1; k < i / nk; k++) rc = gmul(rc, 8'h02);
        t[0] = t[0] ^ rc;
      end else if (nk > 6 && i % nk == 4) begin
        for (int b = 0; b < 4; b++) t[b] = sb[t[b]];
      end
      for (int b = 0; b < 4; b++) wb[i][b] = wb[i-nk][b] ^ t[b];
    end
    for (int i = 0; i < nw; i++) ew[i] = {wb[i][3], wb[i][2], wb[i][1], wb[i][0]};
  endtask

  function automatic logic [127:0] rk_of(int r);
    return {ew[4*r+3], ew[4*r+2], ew[4*r+1], ew[4*r]};
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic kb_lit(logic [255:0] lit);
    for (int m = 0; m < 32; m++) kb[m] = lit[255 - 8*m -: 8];
  endtask

  task automatic kb_rand();
    for (int m = 0; m < 32; m++) kb[m] = 8'($urandom);
  endtask

  task automatic set_key();
    for (int m = 0; m < 32; m++) key[8*m +: 8] = kb[m];
  endtask

  task automatic load(int d);
    set_key();
    chk("key_ready_pre", 128'(kr[d]), 128'd1);
    kv[d] = 1'b1;
    @(negedge clk);
    kv[d] = 1'b0;
    chk("busy_after_accept", 128'(bz[d]), 128'd1);
    chk("sv_low_after_accept", 128'(sv[d]), 128'd0);
  endtask

  task automatic wait_done(int d, int lat);
    int cnt = 0;
    while (!sv[d] && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("latency", 128'(cnt), 128'(lat));
    chk("busy_done", 128'(bz[d]), 128'd0);
  endtask

  task automatic rd(int d, int r, logic [127:0] e);
    idx[d]   = 4'(r);
    rd_en[d] = 1'b1;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    @(negedge clk);
  endtask

  task automatic rd_stop(int d);
    rd_en[d] = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic read_all(int d, int nk);
    for (int r = 0; r <= nk + 6; r++) rd(d, r, rk_of(r));
    rd_stop(d);
  endtask

  // Monitor: a read registered at a posedge is compared at the following negedge.
  initial begin
    logic [1:0] p;
    logic [127:0] e;
    forever begin
      @(posedge clk);
      p = rd_en;
      @(negedge clk);
      for (int d = 0; d < 2; d++) if (p[d]) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          n_chk++; n_fail++;
          $display("FAIL sb_empty: got read on dut %0d expected queued entry", d);
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          chk(d == 0 ? "rk4" : "rk8", rko[d], e);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] kat4, kat8, rk10a;
    int cnt, bad;
    kat4 = {bs(32'hb6630ca6), bs(32'he13f0cc8), bs(32'hc9ee2589), bs(32'hd014f9a8)};
    kat8 = {bs(32'h706c631e), bs(32'h046df344), bs(32'he6188d0b), bs(32'hfe4890d1)};
    kv = '0; rl = '0; idx = '0; rd_en = '0; key = '0; reset = 1'b1;
    for (int x = 0; x < 256; x++) sb[x] = sbox_calc(8'(x));
    repeat (2) @(negedge clk);
    chk("rst_busy", 128'(bz), 128'd0);
    chk("rst_sv", 128'(sv), 128'd0);
    chk("rst_rk4", rko[0], 128'd0);
    chk("rst_rk8", rko[1], 128'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("key_ready_after_reset", 128'(kr), 128'd3);
    for (int r = 0; r <= 10; r++) rd(0, r, 128'd0);
    rd_stop(0);
    for (int r = 0; r <= 14; r++) rd(1, r, 128'd0);
    rd_stop(1);

    // Nk=8: FIPS-197 A.3 then random keys (reloads in DONE)
    kb_lit(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
    model(8); load(1); wait_done(1, 52); read_all(1, 8);
    rd(1, 14, kat8); rd(1, 15, 128'd0); rd_stop(1);
    repeat (2) begin
      kb_rand(); model(8); load(1); wait_done(1, 52); read_all(1, 8);
    end

    // Nk=4: FIPS-197 A.1
    kb_lit({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
    model(4); load(0); wait_done(0, 40); read_all(0, 4);
    rd(0, 10, kat4); rd_stop(0);

    // Reset 20 cycles into expansion, then rerun
    load(0);
    repeat (19) @(negedge clk);
    chk("busy_mid", 128'(bz[0]), 128'd1);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 128'(bz[0]), 128'd0);
    chk("midrst_sv", 128'(sv[0]), 128'd0);
    chk("midrst_rk", rko[0], 128'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    load(0); wait_done(0, 40);
    rd(0, 10, kat4); rd_stop(0);

    // key_valid held through expansion with a changing key
    kb_rand(); model(4); rk10a = rk_of(10); set_key();
    kv[0] = 1'b1;
    @(negedge clk);
    kb_rand(); set_key();
    cnt = 0; bad = 0;
    while (!sv[0] && cnt < 200) begin
      if (kr[0]) bad++;
      @(negedge clk);
      cnt++;
    end
    chk("held_latency", 128'(cnt), 128'd40);
    chk("held_ready_low", 128'(bad), 128'd0);
    chk("ready_in_done", 128'(kr[0]), 128'd1);
    idx[0] = 4'd10; rd_en[0] = 1'b1; q0.push_back(rk10a);
    @(negedge clk);
    rd_en[0] = 1'b0; kv[0] = 1'b0;
    chk("sv_drop_on_reload", 128'(sv[0]), 128'd0);
    chk("busy_on_reload", 128'(bz[0]), 128'd1);
    model(4); wait_done(0, 40); read_all(0, 4);

    // rk_lock in DONE blocks loads
    rl[0] = 1'b1;
    kb_rand(); set_key(); kv[0] = 1'b1;
    #1;
    chk("lock_ready", 128'(kr[0]), 128'd0);
    repeat (3) @(negedge clk);
    chk("lock_sv", 128'(sv[0]), 128'd1);
    chk("lock_busy", 128'(bz[0]), 128'd0);
    kv[0] = 1'b0;
    read_all(0, 4);
    rd(0, 15, 128'd0); rd(0, 11, 128'd0); rd(0, 0, rk_of(0)); rd_stop(0);
    rl[0] = 1'b0;
    #1;
    chk("unlock_ready", 128'(kr[0]), 128'd1);

    repeat (3) @(negedge clk);
    chk("sb_drain4", 128'(q0.size()), 128'd0);
    chk("sb_drain8", 128'(q1.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
